bsg_nasti_slave_mem: RTL and testbench
======================================

Name: bsg_nasti_slave_mem

Overview:
- NASTI slave sitting directly downstream of bsg_nasti_master.
- Consumes AW/W/AR packets and returns B/R packets from a local word-addressed SRAM array.
- Serves as the on-chip test memory and as the bench endpoint for the master's tunnel traffic.
- Processes one transaction at a time; INCR bursts only.

Parameters:
- mem_els_p, 256, number of 64-bit words in the array; power of two, at least 2.
- lg_mem_els_lp, `BSG_SAFE_CLOG2(mem_els_p), local; word index width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-low reset.
- nasti_aw_valid_i  in  1  write address valid.
- nasti_aw_data_i  in  bsg_nasti_a_pkt  write address packet (id, addr, len, size).
- nasti_aw_ready_o  out  1  write address accepted.
- nasti_w_valid_i  in  1  write data valid.
- nasti_w_data_i  in  bsg_nasti_w_pkt  write data packet (data, strb, last).
- nasti_w_ready_o  out  1  write data accepted.
- nasti_b_valid_o  out  1  write response valid.
- nasti_b_data_o  out  bsg_nasti_b_pkt  write response packet (id, resp).
- nasti_b_ready_i  in  1  write response accepted.
- nasti_ar_valid_i  in  1  read address valid.
- nasti_ar_data_i  in  bsg_nasti_a_pkt  read address packet.
- nasti_ar_ready_o  out  1  read address accepted.
- nasti_r_valid_o  out  1  read data valid.
- nasti_r_data_o  out  bsg_nasti_r_pkt  read data packet (id, data, resp, last).
- nasti_r_ready_i  in  1  read data accepted.

Behaviour:
- Reset (reset_i low, asynchronous): all valid and ready outputs 0, FSM in IDLE, beat counter 0, priority flag selects write. Array contents are not reset.
- FSM states: IDLE, WDATA, WRESP, RREAD, RDATA.
- IDLE:
  - aw_ready_o and ar_ready_o are driven combinationally for the selected channel only.
  - Selection: if only one of aw_valid/ar_valid is high, that channel. If both are high, the channel indicated by the priority flag; the flag then toggles, giving alternating priority.
  - On accepting a request, latch id, word index = addr[lg_mem_els_lp+2:3], and len. Clear the beat counter.
  - Set the error flag if size != 3. Address bits above the index are ignored (the array aliases).
  - AW accept -> WDATA. AR accept -> RREAD.
- WDATA:
  - w_ready_o = 1.
  - Each w handshake: if the error flag is clear, write data under strb (byte enables) at the current index. Then increment index mod mem_els_p and the beat counter.
  - If w.last disagrees with (beat counter == len), set the error flag.
  - Exit to WRESP on the beat where the counter equals len, regardless of w.last.
- WRESP:
  - b_valid_o = 1; b.id = latched id; b.resp = 2'b10 (SLVERR) if error flag else 2'b00.
  - Hold until b_ready_i, then -> IDLE.
- RREAD:
  - Issue the synchronous array read at the current index (1-cycle latency) -> RDATA.
- RDATA:
  - r_valid_o = 1; r.data = array output held stable; r.id = latched id.
  - r.resp = SLVERR (data undefined) if error flag, else OKAY. r.last = (beat counter == len).
  - On r_ready_i: if last -> IDLE; else increment index and counter, -> RREAD.
  - Throughput: one beat per 2 cycles.
- Latency: AR accept to first r_valid = 2 cycles. Last w beat to b_valid = 1 cycle.
- Wrap-around: a burst crossing the top of the array wraps to index 0.
- len: 8-bit, so bursts of 1..256 beats; the counter is 8-bit.
- Simultaneous events: AW and AR are never both accepted in one cycle. No new request is accepted until B/R completes.
- Reset mid-burst: the transaction is abandoned, no B/R is issued, and partially written words remain.
- Outputs are held stable while valid is high and ready is low.

Decomposition:
- bsg_nasti_pkg holds bsg_nasti_a_pkt/w_pkt/b_pkt/r_pkt and the resp encodings (nasti_resp_okay, nasti_resp_slverr) as shared constants.
- Sub-module: bsg_mem_1rw_sync_mask_write_byte (mem_els_p x 64, byte-masked) for the array.
- The FSM and burst counter live in this module.

Test Plan:
- Single write, then read: AW id=3 addr=0x40 len=0 size=3; W data=0xDEADBEEF_01234567 strb=0xFF last=1 -> B id=3 resp=OKAY. AR id=3 addr=0x40 len=0 -> R data=0xDEADBEEF_01234567 last=1 resp=OKAY, 2 cycles after AR accept.
- Strobe merge: write 0xFFFF..FF to index 5, then strb=0x0F data=0 -> readback 0xFFFFFFFF_00000000.
- Wrap burst (mem_els_p=256): AW addr=0x7F8 len=3 writes 0,1,2,3 -> reading indices 255,0,1,2 returns 0,1,2,3. r.last asserted only on the 4th beat.
- Backpressure: r_ready_i and b_ready_i held low for 10 cycles -> valid and data stable throughout; one beat completes per ready cycle.
- Contention: aw_valid and ar_valid high together twice in a row -> write served first, then read; the flag alternates.
- Errors and reset:
  - size=2 write -> no array change, B resp=SLVERR.
  - Early w.last at beat 1 of len=3 -> SLVERR after 4 beats.
  - reset_i low mid-read-burst -> r_valid_o 0 immediately; the next request is served normally.

Source files
------------

// File: rtl/bsg_nasti_pkg.sv
// Shared NASTI packet layouts, response codes and the slave FSM state type
// used by the NASTI test-memory slave and its array.
package bsg_nasti_pkg;

  localparam int nasti_id_width_lp   = 6;
  localparam int nasti_addr_width_lp = 32;
  localparam int nasti_data_width_lp = 64;
  localparam int nasti_strb_width_lp = nasti_data_width_lp / 8;

  localparam logic [1:0] nasti_resp_okay   = 2'b00;
  localparam logic [1:0] nasti_resp_slverr = 2'b10;
  localparam logic [2:0] nasti_size_word   = 3'd3;

  typedef struct packed {
    logic [nasti_id_width_lp-1:0]   id;
    logic [nasti_addr_width_lp-1:0] addr;
    logic [7:0]                     len;
    logic [2:0]                     size;
  } bsg_nasti_a_pkt;

  typedef struct packed {
    logic [nasti_data_width_lp-1:0] data;
    logic [nasti_strb_width_lp-1:0] strb;
    logic                           last;
  } bsg_nasti_w_pkt;

  typedef struct packed {
    logic [nasti_id_width_lp-1:0] id;
    logic [1:0]                   resp;
  } bsg_nasti_b_pkt;

  typedef struct packed {
    logic [nasti_id_width_lp-1:0]   id;
    logic [nasti_data_width_lp-1:0] data;
    logic [1:0]                     resp;
    logic                           last;
  } bsg_nasti_r_pkt;

  typedef enum logic [2:0] {
    e_idle,
    e_wdata,
    e_wresp,
    e_rread,
    e_rdata
  } slave_state_e;

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous RAM with per-byte write enables; one byte-wide
// array per lane so each lane maps cleanly onto block RAM.
module bsg_mem_1rw_sync_mask_write_byte
  import bsg_nasti_pkg::*;
#(
  parameter int els_p        = 256,
  parameter int data_width_p = nasti_data_width_lp,
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int mask_width_lp = data_width_p / 8
)
(
  input  logic                     clk_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [data_width_p-1:0]  data_i,
  input  logic [mask_width_lp-1:0] write_mask_i,
  output logic [data_width_p-1:0]  data_o
);

  for (genvar gi = 0; gi < mask_width_lp; gi++) begin : g_lane
    logic [7:0] mem_q [els_p];
    logic [7:0] data_q;

    // Read data only changes on a read access, so it stays put otherwise.
    always_ff @(posedge clk_i) begin
      if (v_i) begin
        if (w_i) begin
          if (write_mask_i[gi]) mem_q[addr_i] <= data_i[gi*8 +: 8];
        end else begin
          data_q <= mem_q[addr_i];
        end
      end
    end

    assign data_o[gi*8 +: 8] = data_q;
  end

endmodule

// File: rtl/bsg_nasti_slave_mem.sv
// NASTI slave backed by a local word-addressed array; serves one INCR burst
// at a time with alternating AW/AR priority under contention.
module bsg_nasti_slave_mem
  import bsg_nasti_pkg::*;
#(
  parameter int mem_els_p = 256
)
(
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           nasti_aw_valid_i,
  input  bsg_nasti_a_pkt nasti_aw_data_i,
  output logic           nasti_aw_ready_o,
  input  logic           nasti_w_valid_i,
  input  bsg_nasti_w_pkt nasti_w_data_i,
  output logic           nasti_w_ready_o,
  output logic           nasti_b_valid_o,
  output bsg_nasti_b_pkt nasti_b_data_o,
  input  logic           nasti_b_ready_i,
  input  logic           nasti_ar_valid_i,
  input  bsg_nasti_a_pkt nasti_ar_data_i,
  output logic           nasti_ar_ready_o,
  output logic           nasti_r_valid_o,
  output bsg_nasti_r_pkt nasti_r_data_o,
  input  logic           nasti_r_ready_i
);

  localparam int lg_mem_els_lp = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;

  slave_state_e                 state_q, state_d;
  logic [nasti_id_width_lp-1:0] id_q, id_d;
  logic [lg_mem_els_lp-1:0]     idx_q, idx_d;
  logic [7:0]                   len_q, len_d;
  logic [7:0]                   cnt_q, cnt_d;
  logic                         err_q, err_d;
  logic                         wr_prio_q, wr_prio_d;

  logic                           aw_sel, ar_sel, last_beat;
  logic                           mem_v, mem_w;
  logic [nasti_data_width_lp-1:0] mem_data_lo;

  // Readies are gated by reset so nothing is accepted while it is held.
  assign aw_sel = (state_q == e_idle) & reset_i & nasti_aw_valid_i
                & (~nasti_ar_valid_i | wr_prio_q);
  assign ar_sel = (state_q == e_idle) & reset_i & nasti_ar_valid_i
                & (~nasti_aw_valid_i | ~wr_prio_q);
  assign last_beat = (cnt_q == len_q);

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    idx_d     = idx_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    wr_prio_d = wr_prio_q;
    mem_v     = 1'b0;
    mem_w     = 1'b0;
    case (state_q)
      e_idle: begin
        if (nasti_aw_valid_i & nasti_ar_valid_i) wr_prio_d = ~wr_prio_q;
        if (aw_sel) begin
          id_d    = nasti_aw_data_i.id;
          idx_d   = nasti_aw_data_i.addr[lg_mem_els_lp+2:3];
          len_d   = nasti_aw_data_i.len;
          cnt_d   = 8'd0;
          err_d   = (nasti_aw_data_i.size != nasti_size_word);
          state_d = e_wdata;
        end else if (ar_sel) begin
          id_d    = nasti_ar_data_i.id;
          idx_d   = nasti_ar_data_i.addr[lg_mem_els_lp+2:3];
          len_d   = nasti_ar_data_i.len;
          cnt_d   = 8'd0;
          err_d   = (nasti_ar_data_i.size != nasti_size_word);
          state_d = e_rread;
        end
      end
      e_wdata: begin
        if (nasti_w_valid_i) begin
          mem_v = ~err_q;
          mem_w = 1'b1;
          idx_d = idx_q + 1'b1;
          cnt_d = cnt_q + 8'd1;
          // The beat count, not w.last, decides where the burst ends.
          if (nasti_w_data_i.last != last_beat) err_d = 1'b1;
          if (last_beat) state_d = e_wresp;
        end
      end
      e_wresp: begin
        if (nasti_b_ready_i) state_d = e_idle;
      end
      e_rread: begin
        mem_v   = 1'b1;
        state_d = e_rdata;
      end
      e_rdata: begin
        if (nasti_r_ready_i) begin
          if (last_beat) begin
            state_d = e_idle;
          end else begin
            idx_d   = idx_q + 1'b1;
            cnt_d   = cnt_q + 8'd1;
            state_d = e_rread;
          end
        end
      end
      default: state_d = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= e_idle;
      id_q      <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      wr_prio_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      wr_prio_q <= wr_prio_d;
    end
  end

  bsg_mem_1rw_sync_mask_write_byte #(
    .els_p        (mem_els_p),
    .data_width_p (nasti_data_width_lp)
  ) mem (
    .clk_i        (clk_i),
    .v_i          (mem_v),
    .w_i          (mem_w),
    .addr_i       (idx_q),
    .data_i       (nasti_w_data_i.data),
    .write_mask_i (nasti_w_data_i.strb),
    .data_o       (mem_data_lo)
  );

  assign nasti_aw_ready_o = aw_sel;
  assign nasti_ar_ready_o = ar_sel;
  assign nasti_w_ready_o  = (state_q == e_wdata);
  assign nasti_b_valid_o  = (state_q == e_wresp);
  assign nasti_r_valid_o  = (state_q == e_rdata);

  assign nasti_b_data_o = '{id: id_q, resp: err_q ? nasti_resp_slverr : nasti_resp_okay};
  assign nasti_r_data_o = '{id:   id_q,
                            data: mem_data_lo,
                            resp: err_q ? nasti_resp_slverr : nasti_resp_okay,
                            last: last_beat};

endmodule

// File: tb/tb_bsg_nasti_slave_mem.sv
// Scoreboard bench for the NASTI test-memory slave: a word model predicts
// B/R packets as requests are issued; each scenario checks what comes back.
module tb_bsg_nasti_slave_mem;
  import bsg_nasti_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_i;
  logic           aw_valid, aw_ready, ar_valid, ar_ready;
  bsg_nasti_a_pkt aw_data, ar_data;
  logic           w_valid, w_ready;
  bsg_nasti_w_pkt w_data;
  logic           b_valid, b_ready, r_valid, r_ready;
  bsg_nasti_b_pkt b_data;
  bsg_nasti_r_pkt r_data;

  bsg_nasti_slave_mem #(.mem_els_p(256)) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .nasti_aw_valid_i (aw_valid),
    .nasti_aw_data_i  (aw_data),
    .nasti_aw_ready_o (aw_ready),
    .nasti_w_valid_i  (w_valid),
    .nasti_w_data_i   (w_data),
    .nasti_w_ready_o  (w_ready),
    .nasti_b_valid_o  (b_valid),
    .nasti_b_data_o   (b_data),
    .nasti_b_ready_i  (b_ready),
    .nasti_ar_valid_i (ar_valid),
    .nasti_ar_data_i  (ar_data),
    .nasti_ar_ready_o (ar_ready),
    .nasti_r_valid_o  (r_valid),
    .nasti_r_data_o   (r_data),
    .nasti_r_ready_i  (r_ready)
  );

  int checks = 0;
  int passed = 0;
  bit exp_wr_prio = 1'b1;

  logic [63:0]    model_mem [256];
  bsg_nasti_b_pkt exp_b_q [$];
  bsg_nasti_r_pkt exp_r_q [$];

  // Write-burst payload used by do_write / model_write.
  logic [63:0] wd [4];
  logic [7:0]  ws [4];
  logic        wl [4];

  function automatic bsg_nasti_a_pkt mk_a(input logic [5:0] id, input logic [31:0] addr,
                                          input logic [7:0] len, input logic [2:0] size);
    bsg_nasti_a_pkt p;
    p.id = id; p.addr = addr; p.len = len; p.size = size;
    return p;
  endfunction

  task automatic model_write(input bsg_nasti_a_pkt a);
    int idx = int'(a.addr[10:3]);
    bit err = (a.size != 3'd3);
    bsg_nasti_b_pkt e;
    for (int i = 0; i <= int'(a.len); i++) begin
      if (!err)
        for (int b = 0; b < 8; b++)
          if (ws[i][b]) model_mem[idx][b*8 +: 8] = wd[i][b*8 +: 8];
      if (wl[i] != (i == int'(a.len))) err = 1'b1;
      idx = (idx + 1) % 256;
    end
    e.id = a.id; e.resp = err ? 2'b10 : 2'b00;
    exp_b_q.push_back(e);
  endtask

  task automatic model_read(input bsg_nasti_a_pkt a);
    int idx = int'(a.addr[10:3]);
    bsg_nasti_r_pkt e;
    for (int i = 0; i <= int'(a.len); i++) begin
      e.id = a.id; e.data = model_mem[idx];
      e.resp = (a.size != 3'd3) ? 2'b10 : 2'b00;
      e.last = (i == int'(a.len));
      exp_r_q.push_back(e);
      idx = (idx + 1) % 256;
    end
  endtask

  // Drivers: called at a negedge, return at a negedge.
  task automatic send_aw(input bsg_nasti_a_pkt p, output bit ok);
    ok = 1'b0; aw_valid = 1'b1; aw_data = p;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (aw_ready) begin @(posedge clk); ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    aw_valid = 1'b0;
  endtask

  task automatic send_ar(input bsg_nasti_a_pkt p, output bit ok);
    ok = 1'b0; ar_valid = 1'b1; ar_data = p;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (ar_ready) begin @(posedge clk); ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    ar_valid = 1'b0;
  endtask

  task automatic send_w(input bsg_nasti_w_pkt p, output bit ok);
    ok = 1'b0; w_valid = 1'b1; w_data = p;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (w_ready) begin @(posedge clk); ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    w_valid = 1'b0;
  endtask

  task automatic get_b(output bsg_nasti_b_pkt p, output int waited, output bit ok);
    ok = 1'b0; waited = 0; p = '0;
    for (int i = 0; i < 50; i++) begin
      if (b_valid) begin ok = 1'b1; break; end
      @(negedge clk); waited++;
    end
    if (ok) begin
      p = b_data; b_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      b_ready = 1'b0;
    end
  endtask

  task automatic get_r(output bsg_nasti_r_pkt p, output int waited, output bit ok);
    ok = 1'b0; waited = 0; p = '0;
    for (int i = 0; i < 50; i++) begin
      if (r_valid) begin ok = 1'b1; break; end
      @(negedge clk); waited++;
    end
    if (ok) begin
      p = r_data; r_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      r_ready = 1'b0;
    end
  endtask

  task automatic do_write(input bsg_nasti_a_pkt a, output bit ok);
    bit o;
    bsg_nasti_w_pkt w;
    send_aw(a, ok);
    model_write(a);
    for (int i = 0; i <= int'(a.len); i++) begin
      w.data = wd[i]; w.strb = ws[i]; w.last = wl[i];
      send_w(w, o);
      ok = ok & o;
    end
  endtask

  task automatic do_read(input bsg_nasti_a_pkt a, output bit ok);
    send_ar(a, ok);
    model_read(a);
  endtask

  task automatic test_reset;
    reset_i = 1'b0; aw_valid = 1'b1; ar_valid = 1'b1; w_valid = 1'b1;
    @(negedge clk); #1;
    checks++; if (aw_ready !== 1'b0) $display("FAIL reset_aw_ready: got %b want 0", aw_ready); else passed++;
    checks++; if (ar_ready !== 1'b0) $display("FAIL reset_ar_ready: got %b want 0", ar_ready); else passed++;
    checks++; if (w_ready !== 1'b0) $display("FAIL reset_w_ready: got %b want 0", w_ready); else passed++;
    checks++; if (b_valid !== 1'b0) $display("FAIL reset_b_valid: got %b want 0", b_valid); else passed++;
    checks++; if (r_valid !== 1'b0) $display("FAIL reset_r_valid: got %b want 0", r_valid); else passed++;
    aw_valid = 1'b0; ar_valid = 1'b0; w_valid = 1'b0;
    @(negedge clk); reset_i = 1'b1; exp_wr_prio = 1'b1;
    @(negedge clk);
    $display("reset: outputs idle");
  endtask

  task automatic test_single_write_read;
    bit ok, ok2; int waited;
    bsg_nasti_b_pkt b, eb; bsg_nasti_r_pkt r, er;
    wd[0] = 64'hDEADBEEF_01234567; ws[0] = 8'hFF; wl[0] = 1'b1;
    do_write(mk_a(6'd3, 32'h40, 8'd0, 3'd3), ok);
    get_b(b, waited, ok2); eb = exp_b_q.pop_front();
    checks++; if (!(ok && ok2)) $display("FAIL single_w_timeout: got %b%b want 11", ok, ok2); else passed++;
    checks++; if (waited != 0) $display("FAIL single_b_latency: got %0d want 0", waited); else passed++;
    checks++; if (b !== eb) $display("FAIL single_b_pkt: got %h want %h", b, eb); else passed++;
    $display("write id=3 addr=0x40 -> b id=%0d resp=%0d", b.id, b.resp);
    do_read(mk_a(6'd3, 32'h40, 8'd0, 3'd3), ok);
    get_r(r, waited, ok2); er = exp_r_q.pop_front();
    checks++; if (!(ok && ok2)) $display("FAIL single_r_timeout: got %b%b want 11", ok, ok2); else passed++;
    checks++; if (waited != 1) $display("FAIL single_r_latency: got %0d want 1", waited); else passed++;
    checks++; if (r !== er) $display("FAIL single_r_pkt: got %h want %h", r, er); else passed++;
    checks++; if (r.data !== 64'hDEADBEEF_01234567) $display("FAIL single_r_data: got %h want deadbeef01234567", r.data); else passed++;
    $display("read id=3 addr=0x40 -> r data=%h last=%b resp=%0d", r.data, r.last, r.resp);
  endtask

  task automatic test_strobe_merge;
    bit ok, ok2; int waited;
    bsg_nasti_b_pkt b, eb; bsg_nasti_r_pkt r, er;
    wd[0] = '1; ws[0] = 8'hFF; wl[0] = 1'b1;
    do_write(mk_a(6'd1, 32'h28, 8'd0, 3'd3), ok);
    get_b(b, waited, ok2); eb = exp_b_q.pop_front();
    checks++; if (b !== eb) $display("FAIL merge_b0: got %h want %h", b, eb); else passed++;
    wd[0] = '0; ws[0] = 8'h0F;
    do_write(mk_a(6'd1, 32'h28, 8'd0, 3'd3), ok);
    get_b(b, waited, ok2); eb = exp_b_q.pop_front();
    checks++; if (b !== eb) $display("FAIL merge_b1: got %h want %h", b, eb); else passed++;
    do_read(mk_a(6'd1, 32'h28, 8'd0, 3'd3), ok);
    get_r(r, waited, ok2); er = exp_r_q.pop_front();
    checks++; if (r !== er) $display("FAIL merge_r_pkt: got %h want %h", r, er); else passed++;
    checks++; if (r.data !== 64'hFFFFFFFF_00000000) $display("FAIL merge_r_data: got %h want ffffffff00000000", r.data); else passed++;
    $display("strobe merge idx 5 -> r data=%h", r.data);
  endtask

  task automatic test_wrap_burst;
    bit ok, ok2; int waited;
    bsg_nasti_b_pkt b, eb; bsg_nasti_r_pkt r, er;
    for (int i = 0; i < 4; i++) begin
      wd[i] = 64'(i); ws[i] = 8'hFF; wl[i] = (i == 3);
    end
    do_write(mk_a(6'd2, 32'h7F8, 8'd3, 3'd3), ok);
    get_b(b, waited, ok2); eb = exp_b_q.pop_front();
    checks++; if (b !== eb) $display("FAIL wrap_b: got %h want %h", b, eb); else passed++;
    do_read(mk_a(6'd2, 32'h7F8, 8'd3, 3'd3), ok);
    for (int i = 0; i < 4; i++) begin
      get_r(r, waited, ok2); er = exp_r_q.pop_front();
      checks++; if (r !== er || waited != 1) $display("FAIL wrap_r_beat%0d: got %h wait %0d want %h wait 1", i, r, waited, er); else passed++;
      $display("wrap beat %0d -> data=%h last=%b", i, r.data, r.last);
    end
    do_read(mk_a(6'd2, 32'h0, 8'd0, 3'd3), ok);
    get_r(r, waited, ok2); er = exp_r_q.pop_front();
    checks++; if (r.data !== 64'd1) $display("FAIL wrap_idx0: got %h want 1", r.data); else passed++;
  endtask

  task automatic test_backpressure;
    bit ok, ok2, stable; int waited;
    bsg_nasti_b_pkt b, eb, bsnap; bsg_nasti_r_pkt r, er, snap;
    do_read(mk_a(6'd8, 32'h7F8, 8'd1, 3'd3), ok);
    for (int beat = 0; beat < 2; beat++) begin
      ok2 = 1'b0;
      for (int i = 0; i < 10 && !ok2; i++) begin
        if (r_valid) ok2 = 1'b1; else @(negedge clk);
      end
      snap = r_data; stable = ok2;
      repeat (10) begin
        @(negedge clk);
        if (r_valid !== 1'b1 || r_data !== snap) stable = 1'b0;
      end
      checks++; if (!stable) $display("FAIL bp_r_stable%0d: got unstable want stable", beat); else passed++;
      get_r(r, waited, ok2); er = exp_r_q.pop_front();
      checks++; if (r !== er) $display("FAIL bp_r_beat%0d: got %h want %h", beat, r, er); else passed++;
      $display("backpressure r beat %0d -> data=%h last=%b", beat, r.data, r.last);
    end
    wd[0] = 64'hA5A5_0F0F_5A5A_F0F0; ws[0] = 8'hFF; wl[0] = 1'b1;
    do_write(mk_a(6'd7, 32'h200, 8'd0, 3'd3), ok);
    bsnap = b_data; stable = (b_valid === 1'b1);
    repeat (10) begin
      @(negedge clk);
      if (b_valid !== 1'b1 || b_data !== bsnap) stable = 1'b0;
    end
    checks++; if (!stable) $display("FAIL bp_b_stable: got unstable want stable"); else passed++;
    get_b(b, waited, ok2); eb = exp_b_q.pop_front();
    checks++; if (b !== eb) $display("FAIL bp_b_pkt: got %h want %h", b, eb); else passed++;
  endtask

  task automatic test_contention;
    bit ok, ok2; int waited;
    bsg_nasti_a_pkt aw_p, aw_p2, ar_p;
    bsg_nasti_w_pkt w;
    bsg_nasti_b_pkt b, eb; bsg_nasti_r_pkt r, er;
    wd[0] = 64'h1111_2222_3333_4444; ws[0] = 8'hFF; wl[0] = 1'b1;
    aw_p = mk_a(6'd4, 32'h80, 8'd0, 3'd3);
    ar_p = mk_a(6'd5, 32'h80, 8'd0, 3'd3);
    aw_valid = 1'b1; aw_data = aw_p; ar_valid = 1'b1; ar_data = ar_p;
    #1;
    checks++; if (aw_ready !== exp_wr_prio || ar_ready !== !exp_wr_prio)
      $display("FAIL contend1_ready: got aw=%b ar=%b want aw=%b ar=%b", aw_ready, ar_ready, exp_wr_prio, !exp_wr_prio); else passed++;
    @(posedge clk); @(negedge clk);
    aw_valid = 1'b0; exp_wr_prio = !exp_wr_prio;
    model_write(aw_p);
    w.data = wd[0]; w.strb = ws[0]; w.last = 1'b1;
    send_w(w, ok);
    get_b(b, waited, ok2); eb = exp_b_q.pop_front();
    checks++; if (b !== eb) $display("FAIL contend_b: got %h want %h", b, eb); else passed++;
    wd[0] = 64'h5555_6666_7777_8888;
    aw_p2 = mk_a(6'd6, 32'h88, 8'd0, 3'd3);
    aw_valid = 1'b1; aw_data = aw_p2;
    #1;
    checks++; if (aw_ready !== exp_wr_prio || ar_ready !== !exp_wr_prio)
      $display("FAIL contend2_ready: got aw=%b ar=%b want aw=%b ar=%b", aw_ready, ar_ready, exp_wr_prio, !exp_wr_prio); else passed++;
    @(posedge clk); @(negedge clk);
    ar_valid = 1'b0; exp_wr_prio = !exp_wr_prio;
    model_read(ar_p);
    get_r(r, waited, ok2); er = exp_r_q.pop_front();
    checks++; if (r !== er) $display("FAIL contend_r: got %h want %h", r, er); else passed++;
    do_write(aw_p2, ok);
    get_b(b, waited, ok2); eb = exp_b_q.pop_front();
    checks++; if (b !== eb) $display("FAIL contend_b2: got %h want %h", b, eb); else passed++;
    $display("contention: write then read served, r data=%h", r.data);
  endtask

  task automatic test_size_error;
    bit ok, ok2; int waited;
    bsg_nasti_b_pkt b, eb; bsg_nasti_r_pkt r, er;
    wd[0] = 64'h1234; ws[0] = 8'hFF; wl[0] = 1'b1;
    do_write(mk_a(6'd10, 32'h28, 8'd0, 3'd2), ok);
    get_b(b, waited, ok2); eb = exp_b_q.pop_front();
    checks++; if (b !== eb || b.resp !== 2'b10) $display("FAIL size_err_b: got %h want %h", b, eb); else passed++;
    do_read(mk_a(6'd10, 32'h28, 8'd0, 3'd3), ok);
    get_r(r, waited, ok2); er = exp_r_q.pop_front();
    checks++; if (r.data !== 64'hFFFFFFFF_00000000 || r !== er) $display("FAIL size_err_unchanged: got %h want %h", r, er); else passed++;
    $display("size=2 write -> b resp=%0d, array kept %h", b.resp, r.data);
  endtask

  task automatic test_early_last;
    bit ok, ok2; int waited;
    bsg_nasti_a_pkt a;
    bsg_nasti_w_pkt w;
    bsg_nasti_b_pkt b, eb; bsg_nasti_r_pkt r, er;
    for (int i = 0; i < 4; i++) begin
      wd[i] = 64'hC0DE_0000 + 64'(i); ws[i] = 8'hFF; wl[i] = (i == 1);
    end
    a = mk_a(6'd11, 32'h100, 8'd3, 3'd3);
    send_aw(a, ok);
    model_write(a);
    for (int i = 0; i < 4; i++) begin
      w.data = wd[i]; w.strb = ws[i]; w.last = wl[i];
      send_w(w, ok2);
      if (i == 2) begin
        checks++; if (b_valid !== 1'b0) $display("FAIL early_last_b_early: got %b want 0", b_valid); else passed++;
      end
    end
    get_b(b, waited, ok2); eb = exp_b_q.pop_front();
    checks++; if (b !== eb || b.resp !== 2'b10 || waited != 0) $display("FAIL early_last_b: got %h wait %0d want %h wait 0", b, waited, eb); else passed++;
    do_read(mk_a(6'd11, 32'h108, 8'd0, 3'd3), ok);
    get_r(r, waited, ok2); er = exp_r_q.pop_front();
    checks++; if (r !== er) $display("FAIL early_last_beat1: got %h want %h", r, er); else passed++;
    $display("early last -> b resp=%0d, idx33=%h", b.resp, r.data);
  endtask

  task automatic test_reset_mid_burst;
    bit ok, ok2, seen; int waited;
    bsg_nasti_b_pkt b, eb; bsg_nasti_r_pkt r, er;
    do_read(mk_a(6'd9, 32'h7F8, 8'd3, 3'd3), ok);
    get_r(r, waited, ok2); er = exp_r_q.pop_front();
    checks++; if (r !== er) $display("FAIL midrst_beat0: got %h want %h", r, er); else passed++;
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      if (r_valid) seen = 1'b1; else @(negedge clk);
    end
    reset_i = 1'b0;
    #1;
    checks++; if (r_valid !== 1'b0 || !seen) $display("FAIL midrst_r_valid: got %b seen %b want 0 seen 1", r_valid, seen); else passed++;
    exp_r_q.delete(); exp_wr_prio = 1'b1;
    @(negedge clk); reset_i = 1'b1;
    @(negedge clk);
    wd[0] = 64'h0BAD_F00D_CAFE_BABE; ws[0] = 8'hFF; wl[0] = 1'b1;
    do_write(mk_a(6'd12, 32'h300, 8'd0, 3'd3), ok);
    get_b(b, waited, ok2); eb = exp_b_q.pop_front();
    checks++; if (b !== eb || !ok2) $display("FAIL midrst_after_b: got %h want %h", b, eb); else passed++;
    do_read(mk_a(6'd12, 32'h300, 8'd0, 3'd3), ok);
    get_r(r, waited, ok2); er = exp_r_q.pop_front();
    checks++; if (r !== er || !ok2) $display("FAIL midrst_after_r: got %h want %h", r, er); else passed++;
    $display("reset mid-burst -> next read data=%h", r.data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

  initial begin
    reset_i = 1'b0;
    aw_valid = 1'b0; ar_valid = 1'b0; w_valid = 1'b0;
    b_ready = 1'b0; r_ready = 1'b0;
    aw_data = '0; ar_data = '0; w_data = '0;
    test_reset;
    test_single_write_read;
    test_strobe_merge;
    test_wrap_burst;
    test_backpressure;
    test_contention;
    test_size_error;
    test_early_last;
    test_reset_mid_burst;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
